posit_mul_sequencer: RTL
========================

POSIT_MUL_SEQUENCER -- requirements
Module: posit_mul_sequencer

Interface
REQ-001 Parameter TIMEOUT, 255, maximum cycles spent in any wait state before abort.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  operation request, sampled only in IDLE.
REQ-005 posit_a, posit_b  input  32 each  operands, latched on accepted start.
REQ-006 op_a, op_b  output  32 each  latched operands to the decoders, stable until next accepted start.
REQ-007 dec_start  output  1  one-cycle start pulse to both decoders.
REQ-008 dec_done_a, dec_done_b  input  1 each  decoder completion.
REQ-009 zero_a, nar_a, zero_b, nar_b  input  1 each  decoder special flags, valid with the matching dec_done.
REQ-010 mul_load, exp_start  output  1 each  one-cycle start pulses to the multiplier and the exponent adder.
REQ-011 mul_done, exp_done, exp_nar, exp_zero  input  1 each  multiplier/exp-adder completion; exp flags valid with exp_done.
REQ-012 adj_start, rnd_start, enc_start  output  1 each  one-cycle start pulses to adjustment, round-off and encoder.
REQ-013 adj_done, rnd_done, enc_done  input  1 each  stage completion.
REQ-014 enc_result  input  32  packed posit from the encoder, valid with enc_done.
REQ-015 posit_result  output  32  final result, held until next accepted start.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 err  output  1  high with done when the operation aborted on timeout.

Function
REQ-019 States SHALL be IDLE, DECODE, MULEXP, ADJUST, ROUND, ENCODE, FINISH.
REQ-020 IDLE with start=1 SHALL latch operands and enter DECODE next cycle; start outside IDLE SHALL be ignored.
REQ-021 Each stage start output SHALL be high for exactly the first cycle in its state and low otherwise; MULEXP pulses mul_load and exp_start together.
REQ-022 Done inputs SHALL be ignored during the pulse cycle and sampled from the following cycle on.
REQ-023 In DECODE and MULEXP each done SHALL be captured in a sticky flag; the state exits once both flags are set, whether or not the dones arrive in the same cycle. Flags clear on state exit.
REQ-024 On DECODE exit: if nar_a|nar_b, result 0x80000000 and go to FINISH; else if zero_a|zero_b, result 0x00000000 and go to FINISH; else go to MULEXP. Flags SHALL be taken from the cycle each decoder's done was captured.
REQ-025 On MULEXP exit: exp_nar gives 0x80000000 and FINISH; else exp_zero gives 0x00000000 and FINISH; else ADJUST. exp_nar SHALL win over exp_zero.
REQ-026 ADJUST->ROUND on adj_done; ROUND->ENCODE on rnd_done; ENCODE->FINISH on enc_done, capturing enc_result into posit_result.
REQ-027 FINISH SHALL assert done for one cycle, then return to IDLE; a start in FINISH is ignored.
REQ-028 A wait counter SHALL clear on every state entry and increment each cycle in DECODE..ENCODE. If it reaches TIMEOUT before exit, the block SHALL go to FINISH with result 0x80000000 and err=1.
REQ-029 err SHALL be cleared on the next accepted start.
REQ-030 Latency with unit-latency stages, start at cycle 0: done high at cycle 11. DECODE special path: cycle 3. MULEXP special path: cycle 5.
REQ-031 posit_result SHALL change only on FINISH entry.

Reset
REQ-032 rst=1 SHALL, on the next clk edge, force IDLE, clear counter and sticky flags, and drive all start outputs, done, busy and err to 0. It SHALL clear posit_result, op_a and op_b to 0x00000000.
REQ-033 rst SHALL take priority over every transition, including mid-operation; no done pulse SHALL follow an aborted operation.

Verification
REQ-034 Normal: a=0x40000000, b=0x40000000, unit-latency stubs, enc_result=0x48000000 -> pulse order dec, mul+exp, adj, rnd, enc; done at cycle 11; posit_result=0x48000000, err=0.
REQ-035 Special: a=0x80000000 (nar_a=1), b=0x00000000 (zero_b=1) -> no mul_load; done at cycle 3; result 0x80000000.
REQ-036 Skewed dones: dec_done_a at cycle 2, dec_done_b at cycle 6 -> mul_load at cycle 7 only. mul_done at 8, exp_done at 10 -> adj_start at 11.
REQ-037 Timeout: adj_done never asserted, TIMEOUT=8 -> FINISH after 8 ADJUST cycles; done=1, err=1, result 0x80000000.
REQ-038 Reset mid-op: rst at cycle 5 of a normal run -> busy=0 next cycle, no done; a new start afterwards completes normally in 11 cycles.
REQ-039 Start while busy: second start at cycle 4 with new operands -> op_a/op_b unchanged, exactly one done.

Source files
------------

// File: rtl/posit_mul_sequencer.sv
`default_nettype none
// ============================================================================
// posit_mul_sequencer: control FSM stepping a posit multiply through decode,
// mul/exp, adjust, round and encode stages with per-state timeout.  Rev 1.0
// ============================================================================
module posit_mul_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] posit_a,
  input  logic [31:0] posit_b,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        dec_start,
  input  logic        dec_done_a,
  input  logic        dec_done_b,
  input  logic        zero_a,
  input  logic        nar_a,
  input  logic        zero_b,
  input  logic        nar_b,
  output logic        mul_load,
  output logic        exp_start,
  input  logic        mul_done,
  input  logic        exp_done,
  input  logic        exp_nar,
  input  logic        exp_zero,
  output logic        adj_start,
  output logic        rnd_start,
  output logic        enc_start,
  input  logic        adj_done,
  input  logic        rnd_done,
  input  logic        enc_done,
  input  logic [31:0] enc_result,
  output logic [31:0] posit_result,
  output logic        done,
  output logic        busy,
  output logic        err
);

  localparam int          CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [31:0] NAR      = 32'h8000_0000;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_MULEXP = 3'd2,
    S_ADJUST = 3'd3,
    S_ROUND  = 3'd4,
    S_ENCODE = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          got_a_q, got_a_d, got_b_q, got_b_d;
  logic          nar_q, nar_d, zero_q, zero_d;
  logic [31:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [31:0]   result_q, result_d;
  logic          err_q, err_d;
  logic          first_cycle;
  logic          wait_st;

  // The counter is zero only in the first cycle of a state, which doubles as the pulse cycle.
  assign first_cycle = (cnt_q == '0);
  assign wait_st     = (state_q == S_DECODE) || (state_q == S_MULEXP) || (state_q == S_ADJUST) ||
                       (state_q == S_ROUND)  || (state_q == S_ENCODE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    got_a_d  = got_a_q;
    got_b_d  = got_b_q;
    nar_d    = nar_q;
    zero_d   = zero_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_a_d  = posit_a;
          op_b_d  = posit_b;
          err_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!first_cycle) begin
          if (dec_done_a && !got_a_q) begin
            got_a_d = 1'b1;
            nar_d   = nar_d | nar_a;
            zero_d  = zero_d | zero_a;
          end
          if (dec_done_b && !got_b_q) begin
            got_b_d = 1'b1;
            nar_d   = nar_d | nar_b;
            zero_d  = zero_d | zero_b;
          end
          if (got_a_d && got_b_d) begin
            if (nar_d) begin
              result_d = NAR;
              state_d  = S_FINISH;
            end else if (zero_d) begin
              result_d = 32'h0;
              state_d  = S_FINISH;
            end else begin
              state_d  = S_MULEXP;
            end
          end
        end
      end
      S_MULEXP: begin
        if (!first_cycle) begin
          if (mul_done) got_a_d = 1'b1;
          if (exp_done && !got_b_q) begin
            got_b_d = 1'b1;
            nar_d   = exp_nar;
            zero_d  = exp_zero;
          end
          if (got_a_d && got_b_d) begin
            if (nar_d) begin
              result_d = NAR;
              state_d  = S_FINISH;
            end else if (zero_d) begin
              result_d = 32'h0;
              state_d  = S_FINISH;
            end else begin
              state_d  = S_ADJUST;
            end
          end
        end
      end
      S_ADJUST: if (!first_cycle && adj_done) state_d = S_ROUND;
      S_ROUND:  if (!first_cycle && rnd_done) state_d = S_ENCODE;
      S_ENCODE: begin
        if (!first_cycle && enc_done) begin
          result_d = enc_result;
          state_d  = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // A stage completing on the last allowed cycle wins over the abort.
    if (wait_st && (state_d == state_q) && (cnt_q == CNT_LAST)) begin
      state_d  = S_FINISH;
      result_d = NAR;
      err_d    = 1'b1;
    end

    if (state_d != state_q) begin
      cnt_d   = '0;
      got_a_d = 1'b0;
      got_b_d = 1'b0;
      nar_d   = 1'b0;
      zero_d  = 1'b0;
    end else if (wait_st) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      got_a_q  <= 1'b0;
      got_b_q  <= 1'b0;
      nar_q    <= 1'b0;
      zero_q   <= 1'b0;
      op_a_q   <= 32'h0;
      op_b_q   <= 32'h0;
      result_q <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      got_a_q  <= got_a_d;
      got_b_q  <= got_b_d;
      nar_q    <= nar_d;
      zero_q   <= zero_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign posit_result = result_q;
  assign err          = err_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FINISH);
  assign dec_start    = (state_q == S_DECODE) && first_cycle;
  assign mul_load     = (state_q == S_MULEXP) && first_cycle;
  assign exp_start    = (state_q == S_MULEXP) && first_cycle;
  assign adj_start    = (state_q == S_ADJUST) && first_cycle;
  assign rnd_start    = (state_q == S_ROUND)  && first_cycle;
  assign enc_start    = (state_q == S_ENCODE) && first_cycle;

endmodule
`default_nettype wire
